rv_decode_stage: RTL and testbench

//  Registered RV32I(+M) decode pipeline stage between fetch and execute.

---
 rtl/rv_decode_stage_if.sv | 35 +++
 rtl/rv_decode_stage.sv | 237 +++++++++++++++++++++++
 tb/tb_rv_decode_stage.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/rv_decode_stage_if.sv
// rtl/rv_decode_stage_if.sv - fetch-side and execute-side handshake bundle for the decode stage
interface rv_decode_stage_if #(
  parameter int PC_W = 32
);
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [PC_W-1:0] in_pc;
  logic [31:0]     in_ir;
  logic            out_valid;
  logic            out_ready;
  logic [PC_W-1:0] out_pc;
  logic [2:0]      out_type;
  logic [6:0]      out_opcode;
  logic [4:0]      out_rd;
  logic [4:0]      out_rs1;
  logic [4:0]      out_rs2;
  logic [2:0]      out_funct3;
  logic [6:0]      out_funct7;
  logic [31:0]     out_imm;
  logic            out_illegal;
  logic [1:0]      out_sys;

  modport master (
    output flush, in_valid, in_pc, in_ir, out_ready,
    input  in_ready, out_valid, out_pc, out_type, out_opcode, out_rd, out_rs1, out_rs2,
           out_funct3, out_funct7, out_imm, out_illegal, out_sys
  );

  modport slave (
    input  flush, in_valid, in_pc, in_ir, out_ready,
    output in_ready, out_valid, out_pc, out_type, out_opcode, out_rd, out_rs1, out_rs2,
           out_funct3, out_funct7, out_imm, out_illegal, out_sys
  );
endinterface

// File: rtl/rv_decode_stage.sv
// rtl/rv_decode_stage.sv - registered RV32I(+M) decode stage with legality checks, skid buffer and flush
module rv_decode_stage #(
  parameter int PC_W = 32,
  parameter int MEXT = 0,
  parameter int SKID = 1
) (
  input logic             clk,
  input logic             rst_n,
  rv_decode_stage_if.slave bus
);

  localparam logic [2:0] INSTR_R   = 3'd0;
  localparam logic [2:0] INSTR_I   = 3'd1;
  localparam logic [2:0] INSTR_S   = 3'd2;
  localparam logic [2:0] INSTR_B   = 3'd3;
  localparam logic [2:0] INSTR_U   = 3'd4;
  localparam logic [2:0] INSTR_J   = 3'd5;
  localparam logic [2:0] INSTR_ERR = 3'd6;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LD     = 7'b0000011;
  localparam logic [6:0] OP_ST     = 7'b0100011;
  localparam logic [6:0] OP_ALUI   = 7'b0010011;
  localparam logic [6:0] OP_ALU    = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_ECSR   = 7'b1110011;

  localparam logic [6:0] F7_BASE   = 7'h00;
  localparam logic [6:0] F7_ALT    = 7'h20;
  localparam logic [6:0] F7_MULDIV = 7'h01;

  localparam logic [31:0] IR_ECALL  = 32'h0000_0073;
  localparam logic [31:0] IR_EBREAK = 32'h0010_0073;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [2:0]      itype;
    logic [6:0]      opcode;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [31:0]     imm;
    logic            illegal;
    logic [1:0]      sys;
  } dec_t;

  logic [31:0] ir;
  logic [6:0]  opc;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic        is_shamt;
  logic        legal;
  logic [2:0]  ty;
  logic [1:0]  sys;
  dec_t        dec;

  dec_t        main_q;
  dec_t        skid_q;
  logic        main_v;
  logic        skid_v;
  logic        in_ready;
  logic        in_acc;
  logic        out_acc;

  assign ir       = bus.in_ir;
  assign opc      = ir[6:0];
  assign f3       = ir[14:12];
  assign f7       = ir[31:25];
  assign is_shamt = (opc == OP_ALUI) && ((f3 == 3'b001) || (f3 == 3'b101));

  // Classification and legality; an illegal word collapses to INSTR_ERR with no sys op.
  always_comb begin
    legal = 1'b0;
    ty    = INSTR_ERR;
    sys   = 2'b00;
    case (opc)
      OP_LUI, OP_AUIPC: begin
        ty    = INSTR_U;
        legal = 1'b1;
      end
      OP_JAL: begin
        ty    = INSTR_J;
        legal = 1'b1;
      end
      OP_JALR: begin
        ty    = INSTR_I;
        legal = (f3 == 3'b000);
      end
      OP_BRANCH: begin
        ty    = INSTR_B;
        legal = (f3 != 3'b010) && (f3 != 3'b011);
      end
      OP_LD: begin
        ty    = INSTR_I;
        legal = (f3 != 3'b011) && (f3 != 3'b110) && (f3 != 3'b111);
      end
      OP_ST: begin
        ty    = INSTR_S;
        legal = (f3 < 3'b011);
      end
      OP_ALUI: begin
        ty = INSTR_I;
        case (f3)
          3'b001:  legal = (f7 == F7_BASE);
          3'b101:  legal = (f7 == F7_BASE) || (f7 == F7_ALT);
          default: legal = 1'b1;
        endcase
      end
      OP_ALU: begin
        ty    = INSTR_R;
        legal = (f7 == F7_BASE)
             || ((f7 == F7_ALT) && ((f3 == 3'b000) || (f3 == 3'b101)))
             || ((MEXT != 0) && (f7 == F7_MULDIV));
      end
      OP_FENCE: begin
        ty    = INSTR_I;
        legal = 1'b1;
      end
      OP_ECSR: begin
        ty = INSTR_I;
        if (f3 == 3'b000) begin
          if (ir == IR_ECALL) begin
            legal = 1'b1;
            sys   = 2'b01;
          end else if (ir == IR_EBREAK) begin
            legal = 1'b1;
            sys   = 2'b10;
          end
        end else if (f3 != 3'b100) begin
          legal = 1'b1;
          sys   = 2'b11;
        end
      end
      default: ;
    endcase
    if (!legal) begin
      ty  = INSTR_ERR;
      sys = 2'b00;
    end
  end

  always_comb begin
    dec         = '0;
    dec.pc      = bus.in_pc;
    dec.itype   = ty;
    dec.opcode  = opc;
    dec.rd      = ir[11:7];
    dec.rs1     = ir[19:15];
    dec.funct3  = f3;
    dec.funct7  = f7;
    dec.illegal = ~legal;
    dec.sys     = sys;
    case (ty)
      INSTR_I: begin
        dec.imm = is_shamt ? {27'd0, ir[24:20]} : {{20{ir[31]}}, ir[31:20]};
      end
      INSTR_S: begin
        dec.rd  = 5'd0;
        dec.rs2 = ir[24:20];
        dec.imm = {{20{ir[31]}}, ir[31:25], ir[11:7]};
      end
      INSTR_B: begin
        dec.rd  = 5'd0;
        dec.rs2 = ir[24:20];
        dec.imm = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
      end
      INSTR_U: begin
        dec.rs1 = 5'd0;
        dec.imm = {ir[31:12], 12'd0};
      end
      INSTR_J: begin
        dec.rs1 = 5'd0;
        dec.imm = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
      end
      INSTR_R: begin
        dec.rs2 = ir[24:20];
      end
      default: ;
    endcase
  end

  // With the skid entry the upstream ready is a flop; without it ready looks through out_ready.
  assign in_ready = (SKID != 0) ? ~skid_v : (~main_v | bus.out_ready);
  assign in_acc   = bus.in_valid & in_ready;
  assign out_acc  = main_v & bus.out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_v <= 1'b0;
      skid_v <= 1'b0;
      main_q <= '0;
      skid_q <= '0;
    end else if (bus.flush) begin
      main_v <= 1'b0;
      skid_v <= 1'b0;
    end else if (out_acc) begin
      if (skid_v) begin
        main_q <= skid_q;
        skid_v <= 1'b0;
      end else begin
        main_v <= in_acc;
        if (in_acc) begin
          main_q <= dec;
        end
      end
    end else if (in_acc) begin
      if (!main_v) begin
        main_v <= 1'b1;
        main_q <= dec;
      end else begin
        skid_v <= 1'b1;
        skid_q <= dec;
      end
    end
  end

  assign bus.in_ready    = in_ready;
  assign bus.out_valid   = main_v;
  assign bus.out_pc      = main_q.pc;
  assign bus.out_type    = main_q.itype;
  assign bus.out_opcode  = main_q.opcode;
  assign bus.out_rd      = main_q.rd;
  assign bus.out_rs1     = main_q.rs1;
  assign bus.out_rs2     = main_q.rs2;
  assign bus.out_funct3  = main_q.funct3;
  assign bus.out_funct7  = main_q.funct7;
  assign bus.out_imm     = main_q.imm;
  assign bus.out_illegal = main_q.illegal;
  assign bus.out_sys     = main_q.sys;

endmodule

// File: tb/tb_rv_decode_stage.sv
// tb/tb_rv_decode_stage.sv - scoreboard bench for rv_decode_stage against an instruction-rule model
module tb_rv_decode_stage;
  localparam int PC_W = 32;
  localparam int MEXT = 0;
  localparam int SKID = 1;

  localparam logic [2:0] T_R = 3'd0, T_I = 3'd1, T_S = 3'd2, T_B = 3'd3;
  localparam logic [2:0] T_U = 3'd4, T_J = 3'd5, T_ERR = 3'd6;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [2:0]      itype;
    logic [6:0]      opcode;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [31:0]     imm;
    logic            illegal;
    logic [1:0]      sys;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rv_decode_stage_if #(.PC_W(PC_W)) bus ();

  rv_decode_stage #(.PC_W(PC_W), .MEXT(MEXT), .SKID(SKID)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  exp_t        sb[$];
  exp_t        mon_e;
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] pc_ctr = 32'h0000_1000;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  function automatic exp_t actual();
    exp_t a;
    a.pc      = bus.out_pc;
    a.itype   = bus.out_type;
    a.opcode  = bus.out_opcode;
    a.rd      = bus.out_rd;
    a.rs1     = bus.out_rs1;
    a.rs2     = bus.out_rs2;
    a.funct3  = bus.out_funct3;
    a.funct7  = bus.out_funct7;
    a.imm     = bus.out_imm;
    a.illegal = bus.out_illegal;
    a.sys     = bus.out_sys;
    return a;
  endfunction

  // Reference: instruction rules written as per-opcode lists, immediates by arithmetic.
  function automatic exp_t model(input logic [31:0] pc, input logic [31:0] ir);
    exp_t        e;
    logic [6:0]  op = ir[6:0];
    logic [2:0]  f3 = ir[14:12];
    logic [6:0]  f7 = ir[31:25];
    logic [2:0]  kind = T_ERR;
    bit          ok = 0;
    bit          shamt = 0;
    logic [1:0]  sy = 2'b00;
    logic signed [31:0] sir = $signed(ir);
    int          v = 0;
    case (op)
      7'h37, 7'h17: begin kind = T_U; ok = 1; end
      7'h6f: begin kind = T_J; ok = 1; end
      7'h63: begin kind = T_B; ok = !(f3 inside {3'd2, 3'd3}); end
      7'h23: begin kind = T_S; ok = (f3 <= 3'd2); end
      7'h33: begin
        kind = T_R;
        ok = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)) || (MEXT == 1 && f7 == 7'h01);
      end
      7'h13: begin
        kind = T_I;
        shamt = (f3 == 3'd1) || (f3 == 3'd5);
        if (f3 == 3'd1) ok = (f7 == 7'h00);
        else if (f3 == 3'd5) ok = (f7 == 7'h00) || (f7 == 7'h20);
        else ok = 1;
      end
      7'h67: begin kind = T_I; ok = (f3 == 3'd0); end
      7'h03: begin kind = T_I; ok = !(f3 inside {3'd3, 3'd6, 3'd7}); end
      7'h0f: begin kind = T_I; ok = 1; end
      7'h73: begin
        kind = T_I;
        if (ir == 32'h0000_0073) begin ok = 1; sy = 2'b01; end
        else if (ir == 32'h0010_0073) begin ok = 1; sy = 2'b10; end
        else if (f3 != 3'd0 && f3 != 3'd4) begin ok = 1; sy = 2'b11; end
      end
      default: ok = 0;
    endcase
    if (!ok) begin kind = T_ERR; sy = 2'b00; end
    case (kind)
      T_I: v = shamt ? int'(ir[24:20]) : int'(sir >>> 20);
      T_S: v = int'(sir >>> 25) * 32 + int'(ir[11:7]);
      T_B: v = (ir[31] ? -4096 : 0) + int'(ir[7]) * 2048 + int'(ir[30:25]) * 32 + int'(ir[11:8]) * 2;
      T_U: v = int'(ir & 32'hFFFF_F000);
      T_J: v = (ir[31] ? -(1 << 20) : 0) + int'(ir[19:12]) * 4096 + int'(ir[20]) * 2048 + int'(ir[30:21]) * 2;
      default: v = 0;
    endcase
    e.pc      = pc;
    e.itype   = kind;
    e.opcode  = op;
    e.rd      = (kind == T_S || kind == T_B) ? 5'd0 : ir[11:7];
    e.rs1     = (kind == T_U || kind == T_J) ? 5'd0 : ir[19:15];
    e.rs2     = (kind == T_R || kind == T_S || kind == T_B) ? ir[24:20] : 5'd0;
    e.funct3  = f3;
    e.funct7  = f7;
    e.imm     = v;
    e.illegal = !ok;
    e.sys     = sy;
    return e;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] r = $urandom;
    logic [6:0]  op;
    logic [6:0]  f7;
    int          sel = $urandom_range(0, 15);
    if (sel == 0) return $urandom;
    if (sel == 1) return 32'h0000_0073;
    if (sel == 2) return 32'h0010_0073;
    case (sel)
      3: op = 7'h37;   4: op = 7'h17;   5: op = 7'h6f;   6: op = 7'h67;
      7: op = 7'h63;   8: op = 7'h03;   9: op = 7'h23;   10: op = 7'h13;
      11: op = 7'h33;  12: op = 7'h0f;  13: op = 7'h73;  14: op = 7'h13;
      default: op = 7'h33;
    endcase
    case ($urandom_range(0, 3))
      0: f7 = 7'h00;
      1: f7 = 7'h20;
      2: f7 = 7'h01;
      default: f7 = r[31:25];
    endcase
    return {f7, r[24:7], op};
  endfunction

  task automatic cycle(input bit v, input logic [31:0] ir, input bit ordy, input bit fl);
    @(negedge clk);
    bus.in_valid  = v;
    bus.in_ir     = ir;
    bus.in_pc     = pc_ctr;
    bus.out_ready = ordy;
    bus.flush     = fl;
    #2;
    if (fl) begin
      sb.delete();
    end else if (v && bus.in_ready) begin
      sb.push_back(model(pc_ctr, ir));
      pc_ctr += 32'd4;
    end
  endtask

  task automatic drain();
    int k = 0;
    while (sb.size() != 0 && k < 50) begin
      cycle(0, 32'h0, 1, 0);
      k++;
    end
    check("drain_done", sb.size(), 0);
  endtask

  always @(negedge clk) begin
    #1;
    if (rst_n && !bus.flush && bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        check("spurious_out", 1, 0);
      end else begin
        mon_e = sb.pop_front();
        check("decode", actual(), mon_e);
      end
    end
  end

  logic [31:0] dir[8] = '{32'h0050_0093, 32'h4031_5193, 32'h0231_5193, 32'h0220_81B3,
                          32'h0010_0073, 32'h0000_0000, 32'h0000_0073, 32'hFFFF_FFFF};

  initial begin
    bus.in_valid  = 0;
    bus.in_ir     = '0;
    bus.in_pc     = '0;
    bus.out_ready = 0;
    bus.flush     = 0;
    repeat (2) @(negedge clk);
    check("reset_out_valid", bus.out_valid, 0);
    check("reset_in_ready", bus.in_ready, 1);
    check("reset_out_data", actual(), '0);
    rst_n = 1;

    for (int i = 0; i < 8; i++) begin
      cycle(1, dir[i], 1, 0);
      check("stream_in_ready", bus.in_ready, 1);
      if (i > 0) check("stream_no_bubble", bus.out_valid, 1);
      case (i)
        1: begin
          check("addi_type", bus.out_type, T_I);
          check("addi_rd", bus.out_rd, 1);
          check("addi_imm", bus.out_imm, 5);
        end
        2: begin
          check("srai_imm", bus.out_imm, 3);
          check("srai_legal", bus.out_illegal, 0);
        end
        3: check("bad_shift_illegal", bus.out_illegal, 1);
        4: check("mul_illegal", bus.out_illegal, (MEXT == 0));
        5: check("ebreak_sys", bus.out_sys, 2'b10);
        6: check("zero_illegal", bus.out_illegal, 1);
        default: ;
      endcase
    end
    drain();

    cycle(1, 32'h0000_0513, 0, 0);
    cycle(1, 32'h0010_0593, 0, 0);
    cycle(1, 32'h0020_0613, 0, 0);
    check("bp_in_ready", bus.in_ready, 0);
    drain();

    cycle(1, 32'h0000_0513, 0, 0);
    cycle(1, 32'h0010_0593, 0, 0);
    cycle(1, 32'h0020_0613, 0, 1);
    cycle(1, 32'h0030_0693, 1, 0);
    check("flush_out_valid", bus.out_valid, 0);
    drain();

    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(0, 3) != 0, rand_instr(), $urandom_range(0, 3) != 0, $urandom_range(0, 63) == 0);
    end
    drain();

    cycle(1, rand_instr(), 0, 0);
    cycle(1, rand_instr(), 0, 0);
    #1 rst_n = 0;
    #1;
    check("reset_async_out_valid", bus.out_valid, 0);
    sb.delete();
    bus.in_valid = 0;
    @(negedge clk);
    rst_n = 1;
    cycle(0, 32'h0, 1, 0);
    check("post_reset_in_ready", bus.in_ready, 1);
    check("post_reset_out_valid", bus.out_valid, 0);

    for (int i = 0; i < 200; i++) begin
      cycle($urandom_range(0, 1) != 0, rand_instr(), $urandom_range(0, 1) != 0, 0);
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
